// File: rtl/game_ctrl.sv
// Minesweeper top-level sequencer: game start/load, button gating, win/lose decision, play timer.
// Optional macro GAME_CTRL_TIMEOUT_EN: when defined, reaching TIME_LIMIT seconds in PLAY loses the game.
module game_ctrl #(
  parameter int NUM_MINES     = 10,
  parameter int NUM_MAPS      = 4,
  parameter int LOAD_CYCLES   = 2,
  parameter int SETTLE_CYCLES = 2,
  parameter int TIME_LIMIT    = 999
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_start,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_sel,
  input  logic        sec_tick,
  input  logic [2:0]  cursor_X,
  input  logic [2:0]  cursor_Y,
  input  logic [63:0] clicked_flat,
  input  logic [5:0]  num_clicked,
  input  logic [63:0] mine_flat,
  output logic        load_new_map,
  output logic        map_btn_up,
  output logic        map_btn_down,
  output logic        map_btn_left,
  output logic        map_btn_right,
  output logic        map_btn_sel,
  output logic [1:0]  map_sel,
  output logic [2:0]  game_state,
  output logic        win,
  output logic        lose,
  output logic [9:0]  secs
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_PLAY  = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_WIN   = 3'd4;
  localparam logic [2:0] S_LOSE  = 3'd5;

  localparam logic [7:0] LOAD_LAST   = 8'(LOAD_CYCLES - 1);
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [5:0] WIN_COUNT   = 6'(64 - NUM_MINES);
  localparam logic [9:0] SECS_MAX    = 10'(TIME_LIMIT);
  localparam logic [1:0] LAST_MAP    = 2'(NUM_MAPS - 1);

  logic [2:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       mine_hit_q, mine_hit_d;
  logic       load_q, load_d;
  logic [4:0] btn_q, btn_d;        // {up, down, left, right, sel}
  logic [1:0] map_sel_q, map_sel_d;
  logic [9:0] secs_q, secs_d;
  logic       win_q, win_d;
  logic       lose_q, lose_d;

  logic [5:0] cell_idx_s;
  logic       timeout_s;

  assign cell_idx_s = {cursor_Y, cursor_X};

`ifdef GAME_CTRL_TIMEOUT_EN
  assign timeout_s = (secs_q == SECS_MAX);
`else
  assign timeout_s = 1'b0;
`endif

  // Next-state, gated button pulses, map selection and timer.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mine_hit_d = mine_hit_q;
    load_d     = 1'b0;
    btn_d      = 5'b00000;
    map_sel_d  = map_sel_q;
    secs_d     = secs_q;

    if ((state_q == S_PLAY || state_q == S_CHECK) && sec_tick && (secs_q != SECS_MAX)) begin
      secs_d = secs_q + 10'd1;
    end else begin
      secs_d = secs_q;
    end

    // Every path into LOAD raises load_new_map and clears secs in the same edge.
    case (state_q)
      S_IDLE: begin
        if (btn_start) begin
          state_d = S_LOAD;
          cnt_d   = 8'd0;
          load_d  = 1'b1;
          secs_d  = 10'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        if (cnt_q == LOAD_LAST) begin
          state_d = S_PLAY;
          cnt_d   = 8'd0;
        end else begin
          cnt_d  = cnt_q + 8'd1;
          load_d = 1'b1;
        end
      end
      S_PLAY: begin
        if (timeout_s) begin
          state_d = S_LOSE;
        end else if (btn_start) begin
          state_d = S_LOAD;
          cnt_d   = 8'd0;
          load_d  = 1'b1;
          secs_d  = 10'd0;
        end else if (btn_sel) begin
          if (clicked_flat[cell_idx_s]) begin
            state_d = S_PLAY;
          end else begin
            btn_d      = 5'b00001;
            mine_hit_d = mine_flat[cell_idx_s];
            state_d    = S_CHECK;
            cnt_d      = 8'd0;
          end
        end else begin
          btn_d = {btn_up, btn_down, btn_left, btn_right, 1'b0};
        end
      end
      S_CHECK: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d = 8'd0;
          if (mine_hit_q) begin
            state_d = S_LOSE;
          end else if (num_clicked == WIN_COUNT) begin
            state_d = S_WIN;
          end else begin
            state_d = S_PLAY;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_WIN, S_LOSE: begin
        if (btn_start) begin
          map_sel_d = (map_sel_q == LAST_MAP) ? 2'd0 : map_sel_q + 2'd1;
          state_d   = S_LOAD;
          cnt_d     = 8'd0;
          load_d    = 1'b1;
          secs_d    = 10'd0;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 8'd0;
      end
    endcase

    win_d  = (state_d == S_WIN);
    lose_d = (state_d == S_LOSE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= 8'd0;
      mine_hit_q <= 1'b0;
      load_q     <= 1'b0;
      btn_q      <= 5'b00000;
      map_sel_q  <= 2'd0;
      secs_q     <= 10'd0;
      win_q      <= 1'b0;
      lose_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mine_hit_q <= mine_hit_d;
      load_q     <= load_d;
      btn_q      <= btn_d;
      map_sel_q  <= map_sel_d;
      secs_q     <= secs_d;
      win_q      <= win_d;
      lose_q     <= lose_d;
    end
  end

  assign load_new_map  = load_q;
  assign map_btn_up    = btn_q[4];
  assign map_btn_down  = btn_q[3];
  assign map_btn_left  = btn_q[2];
  assign map_btn_right = btn_q[1];
  assign map_btn_sel   = btn_q[0];
  assign map_sel       = map_sel_q;
  assign game_state    = state_q;
  assign win           = win_q;
  assign lose          = lose_q;
  assign secs          = secs_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed, table-driven bench for game_ctrl (TIME_LIMIT overridden to 5 to keep the timer test short).
module tb_game_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        btn_start, btn_up, btn_down, btn_left, btn_right, btn_sel, sec_tick;
  logic [2:0]  cursor_X, cursor_Y;
  logic [63:0] clicked_flat, mine_flat;
  logic [5:0]  num_clicked;
  logic        load_new_map, map_btn_up, map_btn_down, map_btn_left, map_btn_right, map_btn_sel;
  logic [1:0]  map_sel;
  logic [2:0]  game_state;
  logic        win, lose;
  logic [9:0]  secs;
  logic [4:0]  obtn;

  int n_chk  = 0;
  int n_fail = 0;

  game_ctrl #(.TIME_LIMIT(5)) dut (
    .clk(clk), .rst_n(rst_n), .btn_start(btn_start),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .btn_sel(btn_sel), .sec_tick(sec_tick), .cursor_X(cursor_X), .cursor_Y(cursor_Y),
    .clicked_flat(clicked_flat), .num_clicked(num_clicked), .mine_flat(mine_flat),
    .load_new_map(load_new_map), .map_btn_up(map_btn_up), .map_btn_down(map_btn_down),
    .map_btn_left(map_btn_left), .map_btn_right(map_btn_right), .map_btn_sel(map_btn_sel),
    .map_sel(map_sel), .game_state(game_state), .win(win), .lose(lose), .secs(secs)
  );

  always #5 clk = ~clk;

  assign obtn = {map_btn_up, map_btn_down, map_btn_left, map_btn_right, map_btn_sel};

  typedef struct {
    logic [4:0] btn;       // {up, down, left, right, sel}
    logic [2:0] cx;
    logic [2:0] cy;
    logic [4:0] exp_btn;
    logic [2:0] exp_state;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_btn(input logic [4:0] b);
    {btn_up, btn_down, btn_left, btn_right, btn_sel} = b;
  endtask

  task automatic pulse_start();
    btn_start = 1'b1;
    step();
    btn_start = 1'b0;
  endtask

  // Called right after the edge that took btn_start.
  task automatic run_load(input logic [1:0] exp_sel);
    chk("load_state0", game_state, 3'd1);
    chk("load_strobe0", load_new_map, 1'b1);
    chk("load_map_sel", map_sel, exp_sel);
    chk("load_secs", secs, 10'd0);
    chk("load_flags", {win, lose}, 2'b00);
    step();
    chk("load_state1", game_state, 3'd1);
    chk("load_strobe1", load_new_map, 1'b1);
    step();
    chk("play_state", game_state, 3'd2);
    chk("play_strobe", load_new_map, 1'b0);
  endtask

  task automatic win_game(input logic [1:0] exp_sel);
    cursor_X = 3'd2; cursor_Y = 3'd0;
    set_btn(5'b00001);
    step();
    chk("win_sel_fwd", obtn, 5'b00001);
    chk("win_check", game_state, 3'd3);
    set_btn(5'b00000);
    num_clicked = 6'd54;
    step();
    chk("win_check2", game_state, 3'd3);
    step();
    chk("win_state", game_state, 3'd4);
    chk("win_flag", win, 1'b1);
    num_clicked = 6'd0;
    pulse_start();
    run_load(exp_sel);
  endtask

  vec_t vecs[6];
  logic [1:0] exp_sel_g;

  initial begin
    vecs[0] = '{btn: 5'b10000, cx: 3'd3, cy: 3'd3, exp_btn: 5'b10000, exp_state: 3'd2};
    vecs[1] = '{btn: 5'b01100, cx: 3'd3, cy: 3'd3, exp_btn: 5'b01100, exp_state: 3'd2};
    vecs[2] = '{btn: 5'b00010, cx: 3'd3, cy: 3'd3, exp_btn: 5'b00010, exp_state: 3'd2};
    vecs[3] = '{btn: 5'b11110, cx: 3'd3, cy: 3'd3, exp_btn: 5'b11110, exp_state: 3'd2};
    vecs[4] = '{btn: 5'b00001, cx: 3'd1, cy: 3'd1, exp_btn: 5'b00000, exp_state: 3'd2};
    vecs[5] = '{btn: 5'b00000, cx: 3'd0, cy: 3'd0, exp_btn: 5'b00000, exp_state: 3'd2};

    rst_n = 1'b0;
    btn_start = 1'b0; sec_tick = 1'b0;
    set_btn(5'b00000);
    cursor_X = 3'd0; cursor_Y = 3'd0;
    clicked_flat = 64'h0000_0000_0000_0200;
    mine_flat    = 64'h0000_0000_0000_0001;
    num_clicked  = 6'd0;
    repeat (2) step();
    chk("rst_state", game_state, 3'd0);
    chk("rst_outs", {load_new_map, obtn, win, lose}, 8'd0);
    chk("rst_map_sel", map_sel, 2'd0);
    chk("rst_secs", secs, 10'd0);
    rst_n = 1'b1;

    // Buttons are ignored in IDLE.
    set_btn(5'b11111);
    step();
    set_btn(5'b00000);
    chk("idle_btn", obtn, 5'b00000);
    chk("idle_state", game_state, 3'd0);

    // Start, with a button dropped during LOAD.
    btn_start = 1'b1;
    step();
    btn_start = 1'b0;
    chk("start_state", game_state, 3'd1);
    chk("start_load", load_new_map, 1'b1);
    btn_up = 1'b1;
    step();
    btn_up = 1'b0;
    chk("load_btn_drop", obtn, 5'b00000);
    chk("load_hold", load_new_map, 1'b1);
    step();
    chk("first_play", game_state, 3'd2);
    chk("first_load_off", load_new_map, 1'b0);
    chk("first_map_sel", map_sel, 2'd0);
    chk("first_secs", secs, 10'd0);

    for (int i = 0; i < 6; i++) begin
      set_btn(vecs[i].btn);
      cursor_X = vecs[i].cx; cursor_Y = vecs[i].cy;
      step();
      set_btn(5'b00000);
      chk($sformatf("vec%0d_btn", i), obtn, vecs[i].exp_btn);
      chk($sformatf("vec%0d_state", i), game_state, vecs[i].exp_state);
      step();
      chk($sformatf("vec%0d_clear", i), obtn, 5'b00000);
    end

    // Select + right: only the select goes through; btn_start at the decision is ignored.
    cursor_X = 3'd2; cursor_Y = 3'd0;
    set_btn(5'b00011);
    step();
    set_btn(5'b00000);
    chk("selr_fwd", obtn, 5'b00001);
    chk("selr_check", game_state, 3'd3);
    num_clicked = 6'd54;
    step();
    chk("selr_check2", game_state, 3'd3);
    btn_start = 1'b1;
    step();
    btn_start = 1'b0;
    chk("selr_win", game_state, 3'd4);
    chk("selr_winflag", win, 1'b1);
    chk("selr_sel_keep", map_sel, 2'd0);
    num_clicked = 6'd0;
    btn_sel = 1'b1;
    step();
    btn_sel = 1'b0;
    chk("win_btn_drop", obtn, 5'b00000);
    chk("win_hold", game_state, 3'd4);
    pulse_start();
    run_load(2'd1);

    win_game(2'd2);
    win_game(2'd3);
    win_game(2'd0);

    // Mine hit at (0,0).
    cursor_X = 3'd0; cursor_Y = 3'd0;
    btn_sel = 1'b1;
    step();
    btn_sel = 1'b0;
    chk("mine_sel_fwd", obtn, 5'b00001);
    chk("mine_check", game_state, 3'd3);
    step();
    chk("mine_check2", game_state, 3'd3);
    step();
    chk("mine_lose", game_state, 3'd5);
    chk("mine_loseflag", lose, 1'b1);
    btn_sel = 1'b1;
    step();
    btn_sel = 1'b0;
    chk("lose_sel_drop", obtn, 5'b00000);
    chk("lose_hold", game_state, 3'd5);
    pulse_start();
    run_load(2'd1);

    // Timer saturation / timeout.
    for (int t = 1; t <= 5; t++) begin
      sec_tick = 1'b1;
      step();
      sec_tick = 1'b0;
      chk($sformatf("tick%0d", t), secs, 10'(t));
    end
    chk("tick_state", game_state, 3'd2);
    sec_tick = 1'b1;
    step();
    sec_tick = 1'b0;
    chk("secs_sat", secs, 10'd5);
`ifdef GAME_CTRL_TIMEOUT_EN
    chk("timeout_state", game_state, 3'd5);
    chk("timeout_lose", lose, 1'b1);
    exp_sel_g = 2'd2;
`else
    chk("no_timeout_state", game_state, 3'd2);
    exp_sel_g = 2'd1;
`endif
    // Restart with a coincident tick: secs must clear.
    btn_start = 1'b1; sec_tick = 1'b1;
    step();
    btn_start = 1'b0; sec_tick = 1'b0;
    run_load(exp_sel_g);

    // Asynchronous reset while a forwarded pulse is out.
    btn_up = 1'b1;
    step();
    btn_up = 1'b0;
    chk("inflight_up", map_btn_up, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_state", game_state, 3'd0);
    chk("async_kill", map_btn_up, 1'b0);
    chk("async_map_sel", map_sel, 2'd0);
    #1 rst_n = 1'b1;
    step();
    chk("post_rst_idle", game_state, 3'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
